// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: glyph table (active-high,
// bit order g..a), blank pattern and nibble width.
package hex_display_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Entry n is the lit pattern of hex digit n; element [15] is written first.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage

// File: rtl/hex_seg7.sv
// Combinational nibble-to-segment decoder, active-high pattern (g..a).
module hex_seg7
  import hex_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  input  logic               blank,
  output logic [6:0]         pattern
);

  always_comb begin
    pattern = blank ? SEG_BLANK : GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: holding register, slot prescaler,
// digit scan, leading-zero blanking and whole-display blink.
module hex_scan_display
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_SLOTS    = 256,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic                          blank_lz,
  input  logic                          blink_en,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         dig_en,
  output logic                          frame_done
);

  localparam int VAL_W = DIGIT_W * NUM_DIGITS;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BL_W  = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_SLOTS - 1);
  localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  logic [VAL_W-1:0]      hold_q, hold_d;
  logic [PS_W-1:0]       ps_q, ps_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BL_W-1:0]       bl_cnt_q, bl_cnt_d;
  logic                  phase_q, phase_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_tick;
  logic [DIGIT_W-1:0]    cur_nibble;
  logic                  upper_nz;
  logic                  digit_blank;
  logic [6:0]            pattern;

  // Timebase: prescaler, digit index and blink phase all step on the slot tick.
  always_comb begin
    slot_tick = (ps_q == PS_LAST);
    hold_d    = load ? value : hold_q;
    ps_d      = slot_tick ? '0 : ps_q + PS_W'(1);
    idx_d     = idx_q;
    bl_cnt_d  = bl_cnt_q;
    phase_d   = phase_q;
    if (slot_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (bl_cnt_q == BL_LAST) begin
        bl_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + BL_W'(1);
      end
    end
  end

  // Digit at idx is a leading zero when it and every more significant nibble is zero.
  always_comb begin
    cur_nibble = '0;
    upper_nz   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = hold_q[i*DIGIT_W +: DIGIT_W];
      end
      if ((IDX_W'(i) >= idx_q) && (hold_q[i*DIGIT_W +: DIGIT_W] != '0)) begin
        upper_nz = 1'b1;
      end
    end
    digit_blank = blank_lz && (idx_q != '0) && !upper_nz;
  end

  hex_seg7 u_seg7 (
    .nibble  (cur_nibble),
    .blank   (digit_blank),
    .pattern (pattern)
  );

  // Output stage is computed from current state, so every visible slot lasts SCAN_DIV cycles.
  always_comb begin
    dig_en_d = '0;
    seg_d    = SEG_OFF;
    if (!(blink_en && phase_q)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_en_d[i] = (idx_q == IDX_W'(i));
      end
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
    end
    frame_done_d = slot_tick && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q       <= '0;
      ps_q         <= '0;
      idx_q        <= '0;
      bl_cnt_q     <= '0;
      phase_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      ps_q         <= ps_d;
      idx_q        <= idx_d;
      bl_cnt_q     <= bl_cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with a per-cycle expected-output queue.
module tb_hex_scan_display;

  logic        clk;
  logic        resetn;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int k_cnt = 0;
  logic [15:0] model_hold = '0;
  logic [11:0] exp_q[$];

  hex_scan_display #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .BLINK_SLOTS    (2),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low segment code of each hex glyph.
  function automatic logic [6:0] seg_lo(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected {dig_en, seg, frame_done} after clock edge k (k=1 is the first edge after reset).
  function automatic logic [11:0] model_out(input int k, input logic [15:0] h,
                                            input logic blz, input logic ben);
    int s, d;
    logic [3:0] dg;
    logic [6:0] sg;
    logic fd;
    s  = (k - 1) / 4;
    d  = s % 4;
    fd = ((k % 16) == 0);
    if (ben && ((s / 2) % 2 == 1)) begin
      dg = 4'b0000;
      sg = 7'b1111111;
    end else begin
      dg = 4'b0001 << d;
      if (blz && (d > 0) && ((h >> (4 * d)) == 16'h0000)) sg = 7'b1111111;
      else sg = seg_lo(h[4*d +: 4]);
    end
    return {dg, sg, fd};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got dig=%b seg=%b fd=%b exp dig=%b seg=%b fd=%b",
             tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // driver: one clock cycle with optional load
  task automatic cycle(input logic ld, input logic [15:0] v);
    logic [11:0] got;
    logic [11:0] exp;
    load  = ld;
    value = v;
    k_cnt++;
    exp_q.push_back(model_out(k_cnt, model_hold, blank_lz, blink_en));
    if (ld) model_hold = v;
    @(posedge clk);
    #1;
    got  = {dig_en, seg, frame_done};
    load = 1'b0;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL queue_empty at k=%0d got=%h exp=none", k_cnt, got);
    end else begin
      exp = exp_q.pop_front();
      check($sformatf("cycle_k%0d", k_cnt), got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom));
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn     = 1'b1;
    k_cnt      = 0;
    model_hold = '0;
  endtask

  initial begin
    resetn   = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {dig_en, seg, frame_done}, {4'b0000, 7'b1111111, 1'b0});
    release_reset();

    // Plain scan of the reset value, one full frame.
    run(16);

    // A5F0 shown without blanking.
    cycle(1'b1, 16'hA5F0);
    run(16);

    // 0007 with leading-zero blanking.
    blank_lz = 1'b1;
    cycle(1'b1, 16'h0007);
    run(16);

    // All zero: digit 0 still shows 0.
    cycle(1'b1, 16'h0000);
    run(16);

    // Middle zero not blanked, upper zeros are.
    cycle(1'b1, 16'h0102);
    run(16);

    // Blink on, random values and blanking mode.
    blink_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      cycle(1'b1, 16'($urandom_range(0, 16'hFFFF)));
      run($urandom_range(3, 9));
    end
    run(16);

    // Load landing exactly on a slot tick.
    blink_en = 1'b0;
    blank_lz = 1'b0;
    while (((k_cnt + 1) % 4) != 0) cycle(1'b0, 16'($urandom));
    cycle(1'b1, 16'h1234);
    run(8);
    while (((k_cnt + 1) % 4) != 0) cycle(1'b0, 16'($urandom));
    cycle(1'b1, 16'hCDEB);
    run(12);

    // Reset in the middle of the slot for digit index 2.
    while (!((((k_cnt - 1) / 4) % 4 == 2) && (((k_cnt - 1) % 4) == 1))) cycle(1'b0, 16'($urandom));
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset", {dig_en, seg, frame_done}, {4'b0000, 7'b1111111, 1'b0});
    @(posedge clk);
    #1;
    check("reset_hold", {dig_en, seg, frame_done}, {4'b0000, 7'b1111111, 1'b0});
    release_reset();
    run(16);

    // Blink phase restarts from zero after reset.
    blink_en = 1'b1;
    run(16);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL queue_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
